clock_time_setter: RTL and testbench
====================================

// Module: clock_time_setter
// PURPOSE
//  User time-setting front end for the digital clock; sits directly upstream of the H/M/S counters.
//  Debounces mode/inc/dec pushbuttons and steps an edit FSM (RUN->HOUR->MIN->SEC->RUN).
//  Drives the counters' set/set_count load path; its run_enable gates their count enable.
//  Provides edit_field/blink for the display stage.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   cycles a synchronised button level must hold before it is accepted (>=2)
//  BLINK_CYCLES     25_000_000  half-period of blink in edit states (>=1)
//  HOUR_MAX         23          max hour value; wrap limit
//  MIN_MAX          59          max minute value; wrap limit
//  SEC_MAX          59          max second value; wrap limit
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  btn_mode    in   1   raw mode button, active-high, asynchronous
//  btn_inc     in   1   raw increment button, active-high, asynchronous
//  btn_dec     in   1   raw decrement button, active-high, asynchronous
//  cur_hour    in   32  live hour counter value
//  cur_min     in   32  live minute counter value
//  cur_sec     in   32  live second counter value
//  set_hour    out  1   1-cycle load strobe to the hour counter
//  set_min     out  1   1-cycle load strobe to the minute counter
//  set_sec     out  1   1-cycle load strobe to the second counter
//  set_value   out  32  load value; valid while any set_* is high
//  run_enable  out  1   1 = counters may count; 0 while editing
//  edit_field  out  2   0=none(RUN), 1=hour, 2=min, 3=sec
//  edit_value  out  32  value currently being edited (0 in RUN)
//  blink       out  1   display blank control for the edited field
// BEHAVIOUR
//  Reset (reset_n=0): state RUN; set_*=0, set_value=0, run_enable=1, edit_field=0, edit_value=0,
//   blink=1; synchronisers, debounce counters and stable levels cleared to 0. Reset mid-edit
//   discards edit_value and emits no set_* strobe.
//  Input path per button: 2-FF synchroniser -> debounce counter. Counter increments while synced
//   level != stable level, clears otherwise; stable level flips when counter reaches
//   DEBOUNCE_CYCLES. Press = 1-cycle pulse on stable rising edge; release produces no event.
//  Latency: raw high before edge 1, held -> FSM reacts at edge DEBOUNCE_CYCLES+3; registered
//   outputs visible after that edge.
//  FSM (events are press pulses):
//   RUN : mode -> HOUR, edit_value <= cur_hour. inc/dec ignored.
//   HOUR: mode -> MIN, set_hour=1, set_value=edit_value, edit_value <= cur_min.
//   MIN : mode -> SEC, set_min=1, set_value=edit_value, edit_value <= cur_sec.
//   SEC : mode -> RUN, set_sec=1, set_value=edit_value, edit_value <= 0.
//  In edit states: inc -> edit_value+1, MAX -> 0; dec -> edit_value-1, 0 -> MAX (MAX = field's
//   parameter). Loaded cur_* greater than MAX is replaced by 0.
//  set_* are high exactly one cycle and are mutually exclusive; set_value holds until next strobe.
//  Simultaneous events in one cycle: mode wins, inc/dec ignored; inc+dec together ignored.
//  run_enable = (state==RUN); edit_field encodes state.
//  blink: 1 in RUN. Entering any edit state restarts phase at 1; toggles every BLINK_CYCLES cycles.
//  All arithmetic 32-bit unsigned; no other overflow paths.
// TESTING (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
//  btn_inc glitch high 2 cycles in HOUR -> edit_value unchanged; held 10 cycles -> exactly +1 at edge 7.
//  cur=12:34:56, mode -> edit_field=1, edit_value=12, run_enable=0; inc x12 -> 23 then wraps to 0.
//  Mode in HOUR/MIN/SEC -> one-cycle set_hour/set_min/set_sec with set_value=0/34/56; then RUN, run_enable=1.
//  MIN with edit_value=0, dec -> 59; inc -> 0; inc+dec pressed together -> unchanged.
//  mode+inc same cycle in HOUR -> moves to MIN, set_value=old hour, no increment.
//  Reset mid-SEC -> RUN, run_enable=1, no set_*; blink toggles every 8 cycles in edit, 1 in RUN.

Source files
------------

// File: rtl/clock_time_setter_if.sv
// Time-setter bundle: raw buttons and live counter values in, load strobes and display controls out.
// Latency: none, wires only.
// Backpressure: none; load strobes are single-cycle and always accepted by the counters.
interface clock_time_setter_if;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [31:0] cur_hour;
  logic [31:0] cur_min;
  logic [31:0] cur_sec;
  logic        set_hour;
  logic        set_min;
  logic        set_sec;
  logic [31:0] set_value;
  logic        run_enable;
  logic [1:0]  edit_field;
  logic [31:0] edit_value;
  logic        blink;

  // Environment side: buttons and counter values in, setter outputs observed.
  modport master (
    output btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
    input  set_hour, set_min, set_sec, set_value, run_enable, edit_field, edit_value, blink
  );

  // Setter side.
  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
    output set_hour, set_min, set_sec, set_value, run_enable, edit_field, edit_value, blink
  );
endinterface

// File: rtl/clock_time_setter.sv
// Debounced-button time editor: RUN->HOUR->MIN->SEC->RUN, loads the H/M/S counters on each field exit.
// Latency: a raw press held from before edge 1 acts at edge DEBOUNCE_CYCLES+3; outputs registered.
// Backpressure: none; set_* strobes last one cycle and the counters must take them.
module clock_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000,
  parameter int unsigned HOUR_MAX        = 23,
  parameter int unsigned MIN_MAX         = 59,
  parameter int unsigned SEC_MAX         = 59
) (
  input  logic               clk,
  input  logic               reset_n,
  clock_time_setter_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [31:0]   HOUR_LIM   = 32'(HOUR_MAX);
  localparam logic [31:0]   MIN_LIM    = 32'(MIN_MAX);
  localparam logic [31:0]   SEC_LIM    = 32'(SEC_MAX);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_t;

  // Button index: 0 = mode, 1 = inc, 2 = dec.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2, stable, stable_q;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    press;

  state_t        state_q, state_d;
  logic [31:0]   edit_q, edit_d;
  logic [31:0]   set_value_q, set_value_d;
  logic          set_hour_q, set_min_q, set_sec_q;
  logic          set_hour_d, set_min_d, set_sec_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [31:0]   field_max;

  assign btn_raw = {bus.btn_dec, bus.btn_inc, bus.btn_mode};
  assign press   = stable & ~stable_q;

  // Out-of-range counter values are loaded as 0 so the edit wrap logic stays closed.
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? 32'd0 : v;
  endfunction

  // Synchronise each button, then accept a new level only after it has held for the full debounce window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Edit FSM next state, edited value, load strobes and blink phase.
  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    set_value_d = set_value_q;
    set_hour_d  = 1'b0;
    set_min_d   = 1'b0;
    set_sec_d   = 1'b0;
    blink_d     = blink_q;
    bcnt_d      = bcnt_q;

    case (state_q)
      S_HOUR:  field_max = HOUR_LIM;
      S_MIN:   field_max = MIN_LIM;
      S_SEC:   field_max = SEC_LIM;
      default: field_max = 32'd0;
    endcase

    if (press[0]) begin
      // Mode has priority; any inc/dec in the same cycle is dropped.
      case (state_q)
        S_RUN: begin
          state_d = S_HOUR;
          edit_d  = clamp(bus.cur_hour, HOUR_LIM);
        end
        S_HOUR: begin
          state_d     = S_MIN;
          set_hour_d  = 1'b1;
          set_value_d = edit_q;
          edit_d      = clamp(bus.cur_min, MIN_LIM);
        end
        S_MIN: begin
          state_d     = S_SEC;
          set_min_d   = 1'b1;
          set_value_d = edit_q;
          edit_d      = clamp(bus.cur_sec, SEC_LIM);
        end
        default: begin
          state_d     = S_RUN;
          set_sec_d   = 1'b1;
          set_value_d = edit_q;
          edit_d      = 32'd0;
        end
      endcase
    end else if (state_q != S_RUN && (press[1] ^ press[2])) begin
      if (press[1]) edit_d = (edit_q == field_max) ? 32'd0 : edit_q + 32'd1;
      else          edit_d = (edit_q == 32'd0) ? field_max : edit_q - 32'd1;
    end

    if (state_d == S_RUN || state_d != state_q) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BLINK_LAST) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d  = bcnt_q + 1'b1;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      edit_q      <= '0;
      set_value_q <= '0;
      set_hour_q  <= 1'b0;
      set_min_q   <= 1'b0;
      set_sec_q   <= 1'b0;
      blink_q     <= 1'b1;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      set_value_q <= set_value_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      blink_q     <= blink_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign bus.set_hour   = set_hour_q;
  assign bus.set_min    = set_min_q;
  assign bus.set_sec    = set_sec_q;
  assign bus.set_value  = set_value_q;
  assign bus.run_enable = (state_q == S_RUN);
  assign bus.edit_field = state_q;
  assign bus.edit_value = edit_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed button sequences, load strobes checked through a scoreboard queue.
// Latency: presses act DEBOUNCE_CYCLES+3 edges after the raw level rises.
// Backpressure: none; the monitor pops one expected record per strobe cycle.
module tb_clock_time_setter;
  localparam int DEB = 4;
  localparam int BLK = 8;

  typedef struct packed {
    logic [2:0]  strobe;   // {sec, min, hour}
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_strobes = 0;

  always #5 clk = ~clk;

  clock_time_setter_if bus();

  clock_time_setter #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLK),
    .HOUR_MAX       (23),
    .MIN_MAX        (59),
    .SEC_MAX        (59)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_view(input string name, input logic [1:0] field, input logic [31:0] value,
                            input logic run_en);
    check({name, "_field"}, 32'(bus.edit_field), 32'(field));
    check({name, "_value"}, bus.edit_value, value);
    check({name, "_run_enable"}, 32'(bus.run_enable), 32'(run_en));
  endtask

  // Hold the given buttons ({dec, inc, mode}) until just after the edge the FSM reacts on.
  task automatic press(input logic [2:0] mask);
    bus.btn_mode = mask[0];
    bus.btn_inc  = mask[1];
    bus.btn_dec  = mask[2];
    repeat (DEB + 3) @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
  endtask

  task automatic settle();
    repeat (DEB + 4) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [2:0] mask);
    press(mask);
    settle();
  endtask

  task automatic expect_strobe(input logic [2:0] strobe, input logic [31:0] value);
    exp_t e;
    e.strobe = strobe;
    e.value  = value;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a load strobe consumes one expected record.
  always @(negedge clk) begin
    logic [2:0] s;
    exp_t e;
    s = {bus.set_sec, bus.set_min, bus.set_hour};
    if (s != 3'b000) begin
      n_strobes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got set=%b value=%0d, expected no strobe", s, bus.set_value);
      end else begin
        e = exp_q.pop_front();
        if (s !== e.strobe || bus.set_value !== e.value) begin
          n_fail++;
          $display("FAIL strobe: got set=%b value=%0d, expected set=%b value=%0d",
                   s, bus.set_value, e.strobe, e.value);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    bus.cur_hour = 32'd12;
    bus.cur_min  = 32'd34;
    bus.cur_sec  = 32'd56;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_view("reset", 2'd0, 32'd0, 1'b1);
    check("reset_blink", 32'(bus.blink), 32'd1);
    check("reset_set_value", bus.set_value, 32'd0);
    check("reset_strobes", 32'({bus.set_sec, bus.set_min, bus.set_hour}), 32'd0);
    reset_n = 1'b1;

    // inc is ignored in RUN
    tap(3'b010);
    check_view("run_inc", 2'd0, 32'd0, 1'b1);

    // Enter HOUR
    tap(3'b001);
    check_view("hour_enter", 2'd1, 32'd12, 1'b0);

    // Two-cycle glitch is filtered
    bus.btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.btn_inc = 1'b0;
    settle();
    check("glitch_value", bus.edit_value, 32'd12);

    // Held 10 cycles: exactly one increment, at edge 7
    bus.btn_inc = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #1;
    check("inc_before_edge7", bus.edit_value, 32'd12);
    @(posedge clk);
    #1;
    check("inc_at_edge7", bus.edit_value, 32'd13);
    repeat (3) @(posedge clk);
    #1;
    bus.btn_inc = 1'b0;
    settle();
    check("inc_held_once", bus.edit_value, 32'd13);

    for (int i = 0; i < 10; i++) tap(3'b010);
    check("hour_at_max", bus.edit_value, 32'd23);
    tap(3'b010);
    check("hour_wrap_up", bus.edit_value, 32'd0);

    // HOUR -> MIN loads hour 0; blink phase restarts at 1 and toggles every 8 cycles
    expect_strobe(3'b001, 32'd0);
    press(3'b001);
    check_view("min_enter", 2'd2, 32'd34, 1'b0);
    check("blink_e0", 32'(bus.blink), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    check("blink_e7", 32'(bus.blink), 32'd1);
    @(posedge clk);
    #1;
    check("blink_e8", 32'(bus.blink), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("blink_e16", 32'(bus.blink), 32'd1);

    tap(3'b010);
    check("min_inc", bus.edit_value, 32'd35);
    tap(3'b100);
    check("min_dec", bus.edit_value, 32'd34);

    expect_strobe(3'b010, 32'd34);
    tap(3'b001);
    check_view("sec_enter", 2'd3, 32'd56, 1'b0);

    expect_strobe(3'b100, 32'd56);
    tap(3'b001);
    check_view("run_return", 2'd0, 32'd0, 1'b1);
    check("run_blink", 32'(bus.blink), 32'd1);

    // Second pass: out-of-range hour clamps to 0, minute starts at 0
    bus.cur_hour = 32'd30;
    bus.cur_min  = 32'd0;
    bus.cur_sec  = 32'd7;
    tap(3'b001);
    check_view("hour_clamp", 2'd1, 32'd0, 1'b0);
    tap(3'b100);
    check("hour_wrap_down", bus.edit_value, 32'd23);

    // mode+inc together: move on, commit 23, no increment applied
    expect_strobe(3'b001, 32'd23);
    tap(3'b011);
    check_view("mode_inc", 2'd2, 32'd0, 1'b0);
    tap(3'b100);
    check("min_wrap_down", bus.edit_value, 32'd59);
    tap(3'b010);
    check("min_wrap_up", bus.edit_value, 32'd0);
    tap(3'b110);
    check("inc_dec_together", bus.edit_value, 32'd0);

    expect_strobe(3'b010, 32'd0);
    tap(3'b001);
    check_view("sec_enter2", 2'd3, 32'd7, 1'b0);

    // Reset mid-SEC discards the edit, no set_sec
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_view("reset_mid_sec", 2'd0, 32'd0, 1'b1);
    check("reset_mid_blink", 32'(bus.blink), 32'd1);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_view("after_reset", 2'd0, 32'd0, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("strobe_count", 32'(n_strobes), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
